// File: rtl/mic4_pulse_sequencer_pkg.sv
// Shared definitions for the Mic4 pulse sequencer: step indices, FSM states,
// width defaults and the enabled-step search used by the sequencer.
package mic4_pulse_sequencer_pkg;

    localparam int DELAY_WIDTH_DEF  = 16;
    localparam int REPEAT_WIDTH_DEF = 16;
    localparam int NUM_STEPS        = 4;

    localparam int STEP_GRST = 0;
    localparam int STEP_S    = 1;
    localparam int STEP_A    = 2;
    localparam int STEP_D    = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FIRE = 2'd1,
        WAIT = 2'd2
    } seq_state_t;

    typedef struct packed {
        logic       found;
        logic [1:0] idx;
    } step_sel_t;

    // Lowest enabled step whose index is >= from; from = 4 means "none left".
    function automatic step_sel_t find_step(input logic [3:0] mask, input logic [2:0] from);
        step_sel_t sel;
        sel = '0;
        for (int i = NUM_STEPS - 1; i >= 0; i--) begin
            if (mask[i] && (3'(i) >= from)) begin
                sel.found = 1'b1;
                sel.idx   = 2'(i);
            end
        end
        return sel;
    endfunction

endpackage

// File: rtl/mic4_pulse_sequencer_seq_delay_timer.sv
// Loadable down-counter that times the gap between sequencer pulses.
// expire is high while the count sits at zero.
module mic4_pulse_sequencer_seq_delay_timer
    import mic4_pulse_sequencer_pkg::*;
#(
    parameter int DELAY_WIDTH = DELAY_WIDTH_DEF
) (
    input  logic                   clk,
    input  logic                   srst,
    input  logic                   load,
    input  logic [DELAY_WIDTH-1:0] value,
    output logic                   expire
);

    logic [DELAY_WIDTH-1:0] cnt_reg;

    always_ff @(posedge clk) begin
        if (srst) begin
            cnt_reg <= '0;
        end else if (load) begin
            cnt_reg <= value;
        end else if (cnt_reg != '0) begin
            cnt_reg <= cnt_reg - DELAY_WIDTH'(1);
        end
    end

    assign expire = (cnt_reg == '0);

endmodule

// File: rtl/mic4_pulse_sequencer.sv
// Fires GRST/STROBE/A/D request pulses in fixed order with programmable gaps
// and repeat count; configuration is captured when a run starts.
module mic4_pulse_sequencer
    import mic4_pulse_sequencer_pkg::*;
#(
    parameter int DELAY_WIDTH  = DELAY_WIDTH_DEF,
    parameter int REPEAT_WIDTH = REPEAT_WIDTH_DEF
) (
    input  logic                    clk_in,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    abort,
    input  logic [3:0]              step_en,
    input  logic [DELAY_WIDTH-1:0]  dly_grst,
    input  logic [DELAY_WIDTH-1:0]  dly_s,
    input  logic [DELAY_WIDTH-1:0]  dly_a,
    input  logic [DELAY_WIDTH-1:0]  dly_d,
    input  logic [REPEAT_WIDTH-1:0] n_repeat,
    output logic                    pulse_grst,
    output logic                    pulse_s,
    output logic                    pulse_a,
    output logic                    pulse_d,
    output logic                    busy,
    output logic                    done,
    output logic [REPEAT_WIDTH-1:0] iter_cnt
);

    seq_state_t              state_reg;
    logic [1:0]              cur_step_reg;
    logic [3:0]              en_reg;
    logic [REPEAT_WIDTH-1:0] n_repeat_reg;
    logic [REPEAT_WIDTH-1:0] iter_cnt_reg;
    logic [3:0]              pulse_reg;
    logic                    busy_reg;
    logic                    done_reg;
    logic [DELAY_WIDTH-1:0]  dly_in  [NUM_STEPS];
    logic [DELAY_WIDTH-1:0]  dly_reg [NUM_STEPS];

    logic                    run_start;
    step_sel_t               start_sel;
    step_sel_t               first_sel;
    step_sel_t               later_sel;
    logic [REPEAT_WIDTH-1:0] iter_cnt_next;
    logic                    more_iters;
    logic                    fire_next;
    logic [1:0]              fire_step;
    logic                    iter_end;
    logic [DELAY_WIDTH-1:0]  timer_value;
    logic                    timer_expire;

    assign dly_in[STEP_GRST] = dly_grst;
    assign dly_in[STEP_S]    = dly_s;
    assign dly_in[STEP_A]    = dly_a;
    assign dly_in[STEP_D]    = dly_d;

    // abort outranks start even while idle, so an abort+start pair starts nothing
    assign run_start = (state_reg == IDLE) && start && !abort;

    always_comb begin
        start_sel     = find_step(step_en, 3'd0);
        first_sel     = find_step(en_reg, 3'd0);
        later_sel     = find_step(en_reg, {1'b0, cur_step_reg} + 3'd1);
        iter_cnt_next = iter_cnt_reg + REPEAT_WIDTH'(1);
        more_iters    = (n_repeat_reg == '0) || (iter_cnt_next != n_repeat_reg);
        fire_next     = 1'b0;
        fire_step     = '0;
        iter_end      = 1'b0;
        timer_value   = '0;
        case (state_reg)
            IDLE: begin
                if (run_start && start_sel.found) begin
                    fire_next   = 1'b1;
                    fire_step   = start_sel.idx;
                    timer_value = dly_in[start_sel.idx];
                end
            end
            FIRE, WAIT: begin
                if (timer_expire) begin
                    if (later_sel.found) begin
                        fire_next   = 1'b1;
                        fire_step   = later_sel.idx;
                        timer_value = dly_reg[later_sel.idx];
                    end else begin
                        iter_end = 1'b1;
                        if (more_iters) begin
                            fire_next   = 1'b1;
                            fire_step   = first_sel.idx;
                            timer_value = dly_reg[first_sel.idx];
                        end
                    end
                end
            end
            default: ;
        endcase
    end

    mic4_pulse_sequencer_seq_delay_timer #(
        .DELAY_WIDTH(DELAY_WIDTH)
    ) u_seq_delay_timer (
        .clk    (clk_in),
        .srst   (rst),
        .load   (fire_next),
        .value  (timer_value),
        .expire (timer_expire)
    );

    for (genvar gi = 0; gi < NUM_STEPS; gi++) begin : g_dly
        always_ff @(posedge clk_in) begin
            if (rst) begin
                dly_reg[gi] <= '0;
            end else if (run_start) begin
                dly_reg[gi] <= dly_in[gi];
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst) begin
            state_reg    <= IDLE;
            cur_step_reg <= '0;
            en_reg       <= '0;
            n_repeat_reg <= '0;
            iter_cnt_reg <= '0;
            pulse_reg    <= '0;
            busy_reg     <= 1'b0;
            done_reg     <= 1'b0;
        end else if (abort && (state_reg != IDLE)) begin
            state_reg <= IDLE;
            pulse_reg <= '0;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
        end else begin
            pulse_reg <= '0;
            done_reg  <= 1'b0;
            if (fire_next) begin
                pulse_reg[fire_step] <= 1'b1;
                cur_step_reg         <= fire_step;
                state_reg            <= FIRE;
                busy_reg             <= 1'b1;
            end
            case (state_reg)
                IDLE: begin
                    if (run_start) begin
                        en_reg       <= step_en;
                        n_repeat_reg <= n_repeat;
                        iter_cnt_reg <= '0;
                        if (!start_sel.found) begin
                            done_reg <= 1'b1;
                        end
                    end
                end
                FIRE, WAIT: begin
                    if (iter_end) begin
                        iter_cnt_reg <= iter_cnt_next;
                        if (!more_iters) begin
                            done_reg  <= 1'b1;
                            busy_reg  <= 1'b0;
                            state_reg <= IDLE;
                        end
                    end else if (!timer_expire) begin
                        state_reg <= WAIT;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign pulse_grst = pulse_reg[STEP_GRST];
    assign pulse_s    = pulse_reg[STEP_S];
    assign pulse_a    = pulse_reg[STEP_A];
    assign pulse_d    = pulse_reg[STEP_D];
    assign busy       = busy_reg;
    assign done       = done_reg;
    assign iter_cnt   = iter_cnt_reg;

endmodule
